// File: rtl/io_map_pkg.sv
// ---------------------------------------------------------------------------
// io_map_pkg
// Purpose : IO memory-map constants shared by the IO address decode and the
//           frame reader, so both agree on the image region bounds. Also holds
//           the frame reader state type.
// Contents: ADDR_W, DATA_W, PROC_BASE, ORIG_BASE, FRAME_WORDS, rd_state_e
// ---------------------------------------------------------------------------
package io_map_pkg;

  localparam int ADDR_W      = 24;      // IO word address width
  localparam int DATA_W      = 8;       // pixel width
  localparam int PROC_BASE   = 120;     // first word of processed image
  localparam int ORIG_BASE   = 160120;  // first word of original image
  localparam int FRAME_WORDS = 160000;  // 400x400 pixels per frame

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/io_frame_reader_if.sv
// ---------------------------------------------------------------------------
// io_frame_reader_if
// Purpose : Bundles the memory read port and the pixel stream of the frame
//           reader.
// Signals : mem_rd/mem_addr (request), mem_rdata (data, one cycle later),
//           pix_valid/pix_data/pix_last/pix_ready (valid/ready stream).
// Modports: master = frame reader, slave = memory + pixel consumer.
// ---------------------------------------------------------------------------
interface io_frame_reader_if #(
  parameter int ADDR_W = io_map_pkg::ADDR_W,
  parameter int DATA_W = io_map_pkg::DATA_W
);

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_last;
  logic              pix_ready;

  modport master (
    output mem_rd, mem_addr,
    input  mem_rdata,
    output pix_valid, pix_data, pix_last,
    input  pix_ready
  );

  modport slave (
    input  mem_rd, mem_addr,
    output mem_rdata,
    input  pix_valid, pix_data, pix_last,
    output pix_ready
  );

endinterface

// File: rtl/io_frame_reader_fifo2.sv
// ---------------------------------------------------------------------------
// fifo2
// Purpose : 2-entry synchronous FIFO holding returned pixels.
// Ports   : clk, rst_n (async active-low), flush (empties FIFO),
//           wr_en/wr_data (push), rd_en (pop), valid (non-empty),
//           rd_data (head, 0 when empty), occ (0..2 entries).
// Callers guarantee no push when full; a push while full is dropped.
// ---------------------------------------------------------------------------
module fifo2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic              valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        occ_q;
  logic              do_wr;
  logic              do_rd;

  assign do_wr   = wr_en & (occ_q != 2'd2) & ~flush;
  assign do_rd   = rd_en & (occ_q != 2'd0) & ~flush;
  assign valid   = (occ_q != 2'd0);
  assign occ     = occ_q;
  assign rd_data = valid ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (do_wr) wr_ptr_q <= ~wr_ptr_q;
      if (do_rd) rd_ptr_q <= ~rd_ptr_q;
      case ({do_wr, do_rd})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/io_frame_reader.sv
// ---------------------------------------------------------------------------
// io_frame_reader
// Purpose : On start, sweeps one image region of the IO map (processed or
//           original), issuing one read per cycle, and streams the returned
//           pixels over a valid/ready handshake.
// Ports   : clk, rst_n (async active-low), start (command, IDLE only),
//           src_sel (0 processed / 1 original, sampled with start),
//           abort (cancel frame), busy (RUN or DRAIN), done (1-cycle pulse
//           after the last pixel is accepted), bus (master side of
//           io_frame_reader_if: memory read port + pixel stream).
// ---------------------------------------------------------------------------
module io_frame_reader #(
  parameter int ADDR_W      = io_map_pkg::ADDR_W,
  parameter int DATA_W      = io_map_pkg::DATA_W,
  parameter int PROC_BASE   = io_map_pkg::PROC_BASE,
  parameter int ORIG_BASE   = io_map_pkg::ORIG_BASE,
  parameter int FRAME_WORDS = io_map_pkg::FRAME_WORDS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               src_sel,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  io_frame_reader_if.master  bus
);

  import io_map_pkg::*;

  localparam int                CNT_W    = $clog2(FRAME_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_WORDS - 1);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  px_cnt_q, px_cnt_d;
  logic              inflight_q;
  logic              done_q, done_d;

  logic [1:0]        occ;
  logic              fifo_valid;
  logic [DATA_W-1:0] fifo_head;
  logic              pop;
  logic              issue;
  logic              fifo_wr;
  logic [2:0]        credit;

  assign pop = fifo_valid & bus.pix_ready;

  // Words already committed to the buffer (stored or returning next cycle).
  // A new read is allowed only if, after this cycle's pop, fewer than two
  // remain; written as occ+inflight < 2+pop to stay unsigned.
  assign credit = {1'b0, occ} + {2'b00, inflight_q};
  assign issue  = (state_q == ST_RUN) & (credit < (3'd2 + {2'b00, pop}));

  // Returning data is only kept while a frame is live; a word landing in
  // the abort cycle or after it belongs to a cancelled frame.
  assign fifo_wr = inflight_q & (state_q != ST_IDLE) & ~abort;

  fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (abort),
    .wr_en   (fifo_wr),
    .wr_data (bus.mem_rdata),
    .rd_en   (pop),
    .valid   (fifo_valid),
    .rd_data (fifo_head),
    .occ     (occ)
  );

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    rd_cnt_d = rd_cnt_q;
    px_cnt_d = px_cnt_q;
    done_d   = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d  = ST_RUN;
            base_d   = src_sel ? ADDR_W'(ORIG_BASE) : ADDR_W'(PROC_BASE);
            rd_cnt_d = '0;
            px_cnt_d = '0;
          end
        end
        ST_RUN: begin
          if (issue) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (rd_cnt_q == LAST_IDX) state_d = ST_DRAIN;
          end
          if (pop) px_cnt_d = px_cnt_q + 1'b1;
        end
        ST_DRAIN: begin
          if (pop) begin
            px_cnt_d = px_cnt_q + 1'b1;
            if (px_cnt_q == LAST_IDX) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      rd_cnt_q   <= '0;
      px_cnt_q   <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      rd_cnt_q   <= rd_cnt_d;
      px_cnt_q   <= px_cnt_d;
      inflight_q <= issue;
      done_q     <= done_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign bus.mem_rd    = issue;
  assign bus.mem_addr  = issue ? (base_q + ADDR_W'(rd_cnt_q)) : '0;
  assign bus.pix_valid = fifo_valid;
  assign bus.pix_data  = fifo_head;
  assign bus.pix_last  = fifo_valid & (px_cnt_q == LAST_IDX);

endmodule

// File: tb/tb_io_frame_reader.sv
module tb_io_frame_reader;

  localparam int FW = 4;
  localparam int PB = 120;
  localparam int OB = 160120;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic start   = 1'b0;
  logic src_sel = 1'b0;
  logic abort   = 1'b0;
  logic busy;
  logic done;

  io_frame_reader_if #(.ADDR_W(24), .DATA_W(8)) bus ();

  io_frame_reader #(
    .ADDR_W(24), .DATA_W(8), .PROC_BASE(PB), .ORIG_BASE(OB), .FRAME_WORDS(FW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .src_sel (src_sel),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // scoreboard state
  int         exp_addr_q [$];
  logic [8:0] exp_pix_q  [$];
  int         issued     = 0;
  int         accepted   = 0;
  int         done_cnt   = 0;
  bit         mon_en     = 1'b0;
  bit         sb_clear   = 1'b0;
  bit         rmode      = 1'b0;
  int         rph        = 0;
  int         mon_pop;
  int         mon_out;
  logic [8:0] mon_e;
  int         mon_a;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // memory model: returns addr[7:0] one cycle after the request
  always @(posedge clk) bus.mem_rdata <= bus.mem_rd ? bus.mem_addr[7:0] : 8'hEE;

  // consumer ready: always 1, or pattern 1,0,0 repeating
  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rph = (rph + 1) % 3;
      bus.pix_ready = rmode ? (rph == 0) : 1'b1;
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (sb_clear) begin
      issued   <= 0;
      accepted <= 0;
    end else if (rst_n && mon_en) begin
      mon_pop = int'(bus.pix_valid & bus.pix_ready);
      mon_out = issued + int'(bus.mem_rd) - accepted - mon_pop;
      check("outstanding_le2", 32'(mon_out <= 2), 1);
      if (bus.mem_rd) begin
        if (exp_addr_q.size() == 0) check("rd_extra", 32'(bus.mem_rd), 0);
        else begin
          mon_a = exp_addr_q.pop_front();
          check("mem_addr", 32'(bus.mem_addr), mon_a);
          $display("rd   addr=%0d", bus.mem_addr);
        end
      end
      if (mon_pop != 0) begin
        if (exp_pix_q.size() == 0) check("pix_extra", 32'(mon_pop), 0);
        else begin
          mon_e = exp_pix_q.pop_front();
          check("pix_data", 32'(bus.pix_data), 32'(mon_e[7:0]));
          check("pix_last", 32'(bus.pix_last), 32'(mon_e[8]));
          $display("pix  data=0x%02h last=%0d", bus.pix_data, bus.pix_last);
        end
      end
      if (done) begin
        check("done_busy_low", 32'(busy), 0);
        check("done_pending", exp_pix_q.size(), 0);
        $display("done at cycle %0d", cyc);
      end
      issued   <= issued + int'(bus.mem_rd);
      accepted <= accepted + mon_pop;
      done_cnt <= done_cnt + int'(done);
    end
  end

  task automatic clear_sb();
    exp_addr_q.delete();
    exp_pix_q.delete();
    sb_clear = 1'b1;
    @(negedge clk);
    #1 sb_clear = 1'b0;
  endtask

  task automatic push_frame(input bit sel);
    int base;
    base = sel ? OB : PB;
    for (int i = 0; i < FW; i++) begin
      exp_addr_q.push_back(base + i);
      exp_pix_q.push_back({(i == FW - 1), 8'(base + i)});
    end
  endtask

  task automatic run_frame(input bit sel, input bit bp, input bit mid_start);
    int c0, d0, n;
    push_frame(sel);
    rmode = bp;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; src_sel = sel; c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; src_sel = ~sel;
    check("busy_rise", 32'(busy), 1);
    check("first_rd", 32'(bus.mem_rd), 1);
    if (mid_start) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 60);
    check("done_seen", 32'(done), 1);
    if (!bp) check("done_latency", 32'(cyc - c0), FW + 3);
    repeat (3) @(negedge clk);
    check("done_count", 32'(done_cnt - d0), 1);
    check("addr_left", exp_addr_q.size(), 0);
    check("pix_left", exp_pix_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, d0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_mem_rd", 32'(bus.mem_rd), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_pix_valid", 32'(bus.pix_valid), 0);
    check("rst_pix_last", 32'(bus.pix_last), 0);
    check("rst_pix_data", 32'(bus.pix_data), 0);
    #21 rst_n = 1'b1;
    mon_en = 1'b1;

    run_frame(1'b0, 1'b0, 1'b0);   // processed, full rate
    run_frame(1'b1, 1'b0, 1'b0);   // original, full rate
    run_frame(1'b0, 1'b1, 1'b0);   // processed, backpressure
    run_frame(1'b1, 1'b0, 1'b1);   // original, start pulsed mid-frame

    // abort together with start in IDLE: stays idle
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    check("abort_start_busy", 32'(busy), 0);
    check("abort_start_rd", 32'(bus.mem_rd), 0);

    // abort after the second accepted pixel
    push_frame(1'b0);
    rmode = 1'b0;
    @(posedge clk); #1 start = 1'b1; src_sel = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    k = 0; n = 0;
    while (k < 2 && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.pix_valid && bus.pix_ready) k++;
    end
    check("abort_reach2", 32'(k), 2);
    d0 = done_cnt;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_pix_valid", 32'(bus.pix_valid), 0);
    check("abort_mem_rd", 32'(bus.mem_rd), 0);
    repeat (6) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 0);
    clear_sb();
    run_frame(1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-frame
    push_frame(1'b1);
    @(posedge clk); #1 start = 1'b1; src_sel = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_mem_rd", 32'(bus.mem_rd), 0);
    check("arst_mem_addr", 32'(bus.mem_addr), 0);
    check("arst_pix_valid", 32'(bus.pix_valid), 0);
    check("arst_pix_last", 32'(bus.pix_last), 0);
    check("arst_pix_data", 32'(bus.pix_data), 0);
    d0 = done_cnt;
    @(posedge clk); #2 rst_n = 1'b1;
    clear_sb();
    repeat (3) @(negedge clk);
    check("arst_no_done", 32'(done_cnt - d0), 0);
    run_frame(1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
